// File: rtl/trial_factor_finder.sv
// Trial-division factor finder: searches upward from divisor 2 for the
// smallest nontrivial factor of a WIDTH-bit product. Each trial runs a
// bit-serial restoring divide. The search stops early once d*d exceeds N,
// which reports the product as prime. Results hold until the next start.
module trial_factor_finder #(
    parameter int WIDTH    = 32,
    parameter bit ODD_ONLY = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   product,
    output logic               busy,
    output logic               done,
    output logic [WIDTH/2-1:0] factor_a,
    output logic [WIDTH-1:0]   factor_b,
    output logic               is_prime
);

    localparam int HW = WIDTH / 2;
    localparam int DW = HW + 1;
    localparam int RW = HW + 2;
    localparam int SW = WIDTH + 2;
    localparam int BW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DIVIDE,
        S_EVAL,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_q;
    logic [DW-1:0]    r_d;
    logic [RW-1:0]    r_rem;
    logic [BW-1:0]    r_bit;
    logic             r_busy;
    logic             r_done;
    logic             r_prime;
    logic [HW-1:0]    r_fa;
    logic [WIDTH-1:0] r_fb;

    // d can reach 2^(WIDTH/2) for products near full scale, so d*d is formed
    // two bits wider than N and can never wrap around.
    logic [SW-1:0]    w_dWide;
    logic [SW-1:0]    w_dSquared;
    logic             w_nBelowTwo;
    logic             w_dTooBig;
    logic [RW-1:0]    w_remShift;
    logic             w_fits;
    logic [RW-1:0]    w_remNext;
    logic [DW-1:0]    w_dNext;

    assign w_dWide     = {{(SW - DW){1'b0}}, r_d};
    assign w_dSquared  = w_dWide * w_dWide;
    assign w_nBelowTwo = (r_n < WIDTH'(2));
    assign w_dTooBig   = (w_dSquared > {2'b00, r_n});

    // One restoring-division step: shift in the next dividend bit, subtract
    // the divisor when it fits and record the matching quotient bit.
    assign w_remShift  = {r_rem[RW-2:0], r_n[r_bit]};
    assign w_fits      = (w_remShift >= {1'b0, r_d});
    assign w_remNext   = w_fits ? (w_remShift - {1'b0, r_d}) : w_remShift;

    // Divisor advance: after 2 only odd candidates when ODD_ONLY is set.
    assign w_dNext = (ODD_ONLY && (r_d == DW'(2))) ? DW'(3)
                   : (r_d + (ODD_ONLY ? DW'(2) : DW'(1)));

    assign busy     = r_busy;
    assign done     = r_done;
    assign factor_a = r_fa;
    assign factor_b = r_fb;
    assign is_prime = r_prime;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decision for the search sequence.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_nextState = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_nBelowTwo || w_dTooBig) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextState = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (r_bit == '0) begin
                    w_nextState = S_EVAL;
                end
            end
            S_EVAL: begin
                if (r_rem == '0) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextState = S_CHECK;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Datapath and result registers; results only change on DONE entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n     <= '0;
            r_q     <= '0;
            r_d     <= '0;
            r_rem   <= '0;
            r_bit   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_prime <= 1'b0;
            r_fa    <= '0;
            r_fb    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_n    <= product;
                        r_d    <= DW'(2);
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (w_nBelowTwo) begin
                        r_fa    <= r_n[HW-1:0];
                        r_fb    <= r_n;
                        r_prime <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_dTooBig) begin
                        r_fa    <= HW'(1);
                        r_fb    <= r_n;
                        r_prime <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_rem <= '0;
                        r_q   <= '0;
                        r_bit <= BW'(WIDTH - 1);
                    end
                end
                S_DIVIDE: begin
                    r_rem      <= w_remNext;
                    r_q[r_bit] <= w_fits;
                    r_bit      <= r_bit - BW'(1);
                end
                S_EVAL: begin
                    if (r_rem == '0) begin
                        r_fa    <= r_d[HW-1:0];
                        r_fb    <= r_q;
                        r_prime <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_d <= w_dNext;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trial_factor_finder.sv
// Scoreboard bench for trial_factor_finder: three instances (32-bit odd-only,
// 16-bit odd-only, 16-bit every-divisor) share clock and reset; one job runs
// at a time and its expected result and completion edge are queued at start.
module tb_trial_factor_finder;

    logic clk = 1'b0;

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    logic        reset;
    logic        startA, startB, startC;
    logic [31:0] productA;
    logic [15:0] productB, productC;
    logic        busyA, busyB, busyC;
    logic        doneA, doneB, doneC;
    logic        primeA, primeB, primeC;
    logic [15:0] faA;
    logic [31:0] fbA;
    logic [7:0]  faB, faC;
    logic [15:0] fbB, fbC;

    trial_factor_finder #(.WIDTH(32), .ODD_ONLY(1'b1)) dutA (
        .clk(clk), .reset(reset), .start(startA), .product(productA),
        .busy(busyA), .done(doneA), .factor_a(faA), .factor_b(fbA), .is_prime(primeA)
    );

    trial_factor_finder #(.WIDTH(16), .ODD_ONLY(1'b1)) dutB (
        .clk(clk), .reset(reset), .start(startB), .product(productB),
        .busy(busyB), .done(doneB), .factor_a(faB), .factor_b(fbB), .is_prime(primeB)
    );

    trial_factor_finder #(.WIDTH(16), .ODD_ONLY(1'b0)) dutC (
        .clk(clk), .reset(reset), .start(startC), .product(productC),
        .busy(busyC), .done(doneC), .factor_a(faC), .factor_b(fbC), .is_prime(primeC)
    );

    typedef struct {
        int          sel;
        logic [31:0] n;
        logic [31:0] a;
        logic [31:0] b;
        logic        prime;
        int          edgeNo;
    } expect_t;

    expect_t     sbQ[$];
    int          errors = 0;
    int          checks = 0;
    int          sel    = 0;
    logic [31:0] obsA, obsB;
    logic        obsBusy, obsDone, obsPrime;

    // Route the selected instance's outputs onto one zero-extended view.
    always_comb begin
        obsA     = {16'd0, faA};
        obsB     = fbA;
        obsBusy  = busyA;
        obsDone  = doneA;
        obsPrime = primeA;
        case (sel)
            1: begin
                obsA = {24'd0, faB}; obsB = {16'd0, fbB};
                obsBusy = busyB; obsDone = doneB; obsPrime = primeB;
            end
            2: begin
                obsA = {24'd0, faC}; obsB = {16'd0, fbC};
                obsBusy = busyC; obsDone = doneC; obsPrime = primeC;
            end
            default: ;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s (sel=%0d): got %0d, expected %0d", tag, sel, observed, expected);
        end
    endtask

    function automatic expect_t mk(input int s, input logic [31:0] n, input logic [31:0] a,
                                   input logic [31:0] b, input logic p, input int e);
        expect_t x;
        x.sel = s; x.n = n; x.a = a; x.b = b; x.prime = p; x.edgeNo = e;
        return x;
    endfunction

    // Reference: straightforward trial division with the documented trial cost.
    function automatic expect_t model(input int s, input logic [31:0] n);
        expect_t x;
        longint  w   = (s == 0) ? 32 : 16;
        bit      odd = (s != 2);
        longint  nn  = longint'(n);
        longint  d   = 2;
        longint  k   = 0;
        x.sel = s; x.n = n;
        if (nn < 2) begin
            x.a = n; x.b = n; x.prime = 1'b0; x.edgeNo = 1;
            return x;
        end
        while (1) begin
            if (d * d > nn) begin
                x.a = 1; x.b = n; x.prime = 1'b1; x.edgeNo = int'(k * (w + 2) + 1);
                return x;
            end
            k++;
            if (nn % d == 0) begin
                x.a = 32'(d); x.b = 32'(nn / d); x.prime = 1'b0; x.edgeNo = int'(k * (w + 2));
                return x;
            end
            d = (odd && d == 2) ? 3 : (odd ? d + 2 : d + 1);
        end
        return x;
    endfunction

    task automatic driveStart(input int s, input logic v, input logic [31:0] n);
        case (s)
            1:       begin startB = v; productB = n[15:0]; end
            2:       begin startC = v; productC = n[15:0]; end
            default: begin startA = v; productA = n; end
        endcase
    endtask

    // Issue one start (edge 0 is the edge that samples it) and queue the expectation.
    task automatic applyStimulus(input expect_t e, input bit hold);
        sbQ.push_back(e);
        @(negedge clk);
        sel = e.sel;
        driveStart(e.sel, 1'b1, e.n);
        @(posedge clk);
        #1;
        if (!hold) driveStart(e.sel, 1'b0, e.n);
        checkOutput("busy_edge0", {31'd0, obsBusy}, 32'd1);
        checkOutput("done_edge0", {31'd0, obsDone}, 32'd0);
    endtask

    // Wait (bounded) for done, optionally disturbing start/product mid-run, then score.
    task automatic awaitResult(input bit disturb);
        int      edges = 0;
        bit      got   = 1'b0;
        expect_t e;
        if (sbQ.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sbQ[0];
        while (!got && edges < 6000) begin
            if (disturb && edges == 10) driveStart(sel, 1'b1, 32'd7);
            if (disturb && edges == 11) driveStart(sel, 1'b0, 32'd7);
            @(posedge clk);
            edges++;
            #1;
            got = obsDone;
            if (edges == e.edgeNo - 1 && edges > 0 && !got)
                checkOutput("busy_before_done", {31'd0, obsBusy}, 32'd1);
        end
        e = sbQ.pop_front();
        if (!got) begin
            checkOutput("timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("done_edge", 32'(edges), 32'(e.edgeNo));
            checkOutput("factor_a", obsA, e.a);
            checkOutput("factor_b", obsB, e.b);
            checkOutput("is_prime", {31'd0, obsPrime}, {31'd0, e.prime});
            checkOutput("busy_at_done", {31'd0, obsBusy}, 32'd0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, obsBusy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, obsDone}, 32'd0);
        checkOutput({tag, "_a"}, obsA, 32'd0);
        checkOutput({tag, "_b"}, obsB, 32'd0);
        checkOutput({tag, "_prime"}, {31'd0, obsPrime}, 32'd0);
    endtask

    // Main sequence: reset, directed cases, robustness cases, random cases.
    initial begin
        expect_t plan[$];
        reset = 1'b1;
        startA = 1'b0; startB = 1'b0; startC = 1'b0;
        productA = '0; productB = '0; productC = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checkAllZero("reset");
        end
        reset = 1'b0;

        plan.push_back(mk(0, 15, 3, 5, 1'b0, 68));
        plan.push_back(mk(0, 13, 1, 13, 1'b1, 69));
        plan.push_back(mk(0, 4, 2, 2, 1'b0, 34));
        plan.push_back(mk(0, 0, 0, 0, 1'b0, 1));
        plan.push_back(mk(0, 1, 1, 1, 1'b0, 1));
        plan.push_back(mk(1, 65521, 1, 65521, 1'b1, 2305));
        plan.push_back(mk(2, 65521, 1, 65521, 1'b1, 4573));
        plan.push_back(mk(1, 65535, 3, 21845, 1'b0, 36));
        plan.push_back(mk(1, 65025, 3, 21675, 1'b0, 36));
        plan.push_back(mk(1, 64009, 11, 5819, 1'b0, 108));
        foreach (plan[i]) begin
            applyStimulus(plan[i], 1'b0);
            awaitResult(1'b0);
        end

        // Start pulse and product change while busy must not disturb the result.
        applyStimulus(mk(0, 15, 3, 5, 1'b0, 68), 1'b0);
        awaitResult(1'b1);

        // Start held high: the second search is accepted in the first DONE cycle.
        applyStimulus(mk(0, 15, 3, 5, 1'b0, 68), 1'b1);
        awaitResult(1'b0);
        @(posedge clk);
        #1;
        checkOutput("restart_done", {31'd0, obsDone}, 32'd0);
        checkOutput("restart_busy", {31'd0, obsBusy}, 32'd1);
        driveStart(0, 1'b0, 32'd15);
        sbQ.push_back(mk(0, 15, 3, 5, 1'b0, 68));
        awaitResult(1'b0);

        // Reset sampled at edge 20 of a run aborts it; a fresh start then completes.
        @(negedge clk);
        sel = 0;
        driveStart(0, 1'b1, 32'd15);
        @(posedge clk);
        #1;
        driveStart(0, 1'b0, 32'd15);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkAllZero("midrun_reset");
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_after_reset_done", {31'd0, obsDone}, 32'd0);
        checkOutput("idle_after_reset_busy", {31'd0, obsBusy}, 32'd0);
        applyStimulus(mk(0, 15, 3, 5, 1'b0, 68), 1'b0);
        awaitResult(1'b0);

        // Random 16-bit products on both 16-bit variants.
        for (int i = 0; i < 6; i++) begin
            int          s;
            logic [31:0] n;
            s = 1 + (i % 2);
            n = 32'($urandom_range(2, 65535));
            applyStimulus(model(s, n), 1'b0);
            awaitResult(1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trial_factor_finder.md
Name: trial_factor_finder

Overview:
- Parametrised successor of the fixed 32-bit trial-division factor finder.
- Accepts a WIDTH-bit product on a start handshake and searches upward from divisor 2 for the smallest nontrivial factor.
- Each trial uses an internal bit-serial restoring divider. Search stops early at d*d > N and reports primality.
- Sits ahead of the Pollard p-1 datapath as the small-factor pre-filter; results are held stable until the next start.

Parameters:
WIDTH, 32, product width in bits; must be even and >= 8
ODD_ONLY, 1, 1: test divisor 2 and then odd divisors only; 0: test every integer divisor

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous active-high reset
start  input  1  request pulse; sampled only in IDLE or DONE
product  input  WIDTH  value N to factor; captured on the accepted start edge
busy  output  1  high from the edge after start is accepted until done rises
done  output  1  level; high in DONE state until the next accepted start or reset
factor_a  output  WIDTH/2  smallest factor found, 1 if N is prime
factor_b  output  WIDTH  cofactor N/factor_a, N if prime
is_prime  output  1  valid while done=1

Behaviour:
- Reset (synchronous, highest priority, valid in any state including mid-divide): state=IDLE; busy=0, done=0, factor_a=0, factor_b=0, is_prime=0; internal d, N, quotient, remainder and bit counter cleared.
- States: IDLE, CHECK, DIVIDE, EVAL, DONE.
- IDLE/DONE with start=1: latch N=product, d=2, busy=1, done=0 -> CHECK. Start in any other state is ignored.
- CHECK (1 cycle):
  - If N<2 -> DONE with factor_a=N[WIDTH/2-1:0], factor_b=N, is_prime=0.
  - Else if d*d > N -> DONE with factor_a=1, factor_b=N, is_prime=1.
  - Else clear remainder and quotient, load bit counter=WIDTH-1 -> DIVIDE.
  - d is held in WIDTH/2+1 bits; d*d is computed in WIDTH+2 bits so it never wraps. This matters at N near 2^WIDTH-1, where d reaches 2^(WIDTH/2).
- DIVIDE (exactly WIDTH cycles, MSB first):
  - rem' = {rem, N[bit]}; if rem' >= d then rem' -= d and q[bit]=1.
  - The remainder register is WIDTH/2+2 bits wide.
  - After bit 0 -> EVAL.
- EVAL (1 cycle):
  - If rem==0 -> DONE with factor_a=d, factor_b=q, is_prime=0.
  - Else advance d -> CHECK:
    - ODD_ONLY=1: 2->3, otherwise d+2.
    - ODD_ONLY=0: d+1.
- DONE: busy=0, done=1; outputs are frozen. Outputs change only on DONE entry or reset.
- Timing (edge 0 = the start-sampling edge):
  - A trial costs WIDTH+2 cycles.
  - Hit on the k-th trial: done visible after edge k*(WIDTH+2).
  - Prime after k failing trials: done visible after edge k*(WIDTH+2)+1.
  - N<2: done visible after edge 1.
- Start held high continuously: one search runs; a new search is accepted in the first DONE cycle.
- Product changing while busy has no effect.

Test Plan:
- WIDTH=32, ODD_ONLY=1, product=15, start pulse -> done after edge 68; factor_a=3, factor_b=5, is_prime=0; busy high edges 1..67.
- WIDTH=32, product=13 -> trials d=2,3 miss; d=5 fails CHECK; done after edge 69; factor_a=1, factor_b=13, is_prime=1.
- WIDTH=32, product=4 -> done after edge 34; factor_a=2, factor_b=2. Also product=0 -> done after edge 1 with a=0, b=0, is_prime=0. Also product=1 -> done after edge 1 with a=1, b=1, is_prime=0.
- WIDTH=16, ODD_ONLY=1, product=65521 -> 128 trials; done after edge 2305; factor_a=1, factor_b=65521, is_prime=1. Repeat with ODD_ONLY=0 -> 254 trials; done after edge 4573.
- WIDTH=16, product=65535 -> factor_a=3, factor_b=21845. Also product=65025 -> factor_a=3, factor_b=21675. Also product=64009 (=253^2, 11*23 squared) -> factor_a=11, factor_b=5819.
- Assert reset at edge 20 of a product=15 run -> all outputs 0 next cycle, state IDLE. A fresh start completes normally. Start pulses while busy are ignored; changing product mid-run leaves the result unchanged.
